// File: rtl/serial_addsub_unit_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor and its
// single-bit arithmetic cell.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic MODE_ADD  = 1'b0;
   localparam logic MODE_SUB  = 1'b1;
   localparam logic MODE_HALF = 1'b0;
   localparam logic MODE_FULL = 1'b1;

   // Width of a counter that must hold the values 0..width.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_addsub_unit_if.sv
// Request/result bundle between the operand source and the serial add/sub unit.
interface serial_addsub_unit_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             modeAddSubtract;
   logic             modeHalfFull;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carryborrowIn;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sumdiff;
   logic             carryborrowOut;
   logic             overflow;

   modport master (
      output start, modeAddSubtract, modeHalfFull, a, b, carryborrowIn,
      input  busy, done, sumdiff, carryborrowOut, overflow
   );

   modport slave (
      input  start, modeAddSubtract, modeHalfFull, a, b, carryborrowIn,
      output busy, done, sumdiff, carryborrowOut, overflow
   );

endinterface

// File: rtl/serial_addsub_unit_bit_cell.sv
// Combinational one-bit full adder / full subtractor; subtract computes a - b - c
// and reports the borrow.
module addsub_bit_cell
   import addsub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic modeAddSubtract,
   output logic result,
   output logic carryborrowOut
);

   assign result = a ^ b ^ c;

   assign carryborrowOut = (modeAddSubtract == MODE_SUB)
                         ? ((~a & b) | (c & ~(a ^ b)))
                         : (( a & b) | (c &  (a ^ b)));

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through a
// single add/sub cell with a carry/borrow flip-flop.
module serial_addsub_unit
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 resetN,
   serial_addsub_unit_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sumdiff_q, sumdiff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic             cbo_q, cbo_d;
   logic             ovf_q, ovf_d;

   logic             bit_res;
   logic             bit_cb;
   logic             last_bit;
   logic             ovf_bit;

   addsub_bit_cell u_cell (
      .a               (a_q[0]),
      .b               (b_q[0]),
      .c               (carry_q),
      .modeAddSubtract (sub_q),
      .result          (bit_res),
      .carryborrowOut  (bit_cb)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // On the last bit a_q[0]/b_q[0] are the operand MSBs and bit_res is the result MSB.
   assign ovf_bit = (sub_q == MODE_SUB)
                  ? ((a_q[0] != b_q[0]) && (bit_res != a_q[0]))
                  : ((a_q[0] == b_q[0]) && (bit_res != a_q[0]));

   // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      sumdiff_d = sumdiff_q;
      cnt_d     = cnt_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      cbo_d     = cbo_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               a_d     = bus.a;
               b_d     = bus.b;
               sub_d   = bus.modeAddSubtract;
               carry_d = bus.carryborrowIn & (bus.modeHalfFull == MODE_FULL);
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = bit_cb;
            res_d   = WIDTH'({bit_res, res_q} >> 1);
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               state_d   = DONE;
               sumdiff_d = res_d;
               cbo_d     = bit_cb;
               ovf_d     = ovf_bit;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         sumdiff_q <= '0;
         cnt_q     <= '0;
         sub_q     <= 1'b0;
         carry_q   <= 1'b0;
         cbo_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         sumdiff_q <= sumdiff_d;
         cnt_q     <= cnt_d;
         sub_q     <= sub_d;
         carry_q   <= carry_d;
         cbo_q     <= cbo_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.busy           = (state_q != IDLE);
   assign bus.done           = (state_q == DONE);
   assign bus.sumdiff        = sumdiff_q;
   assign bus.carryborrowOut = cbo_q;
   assign bus.overflow       = ovf_q;

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Parametrised bit-serial adder/subtractor and the sequential successor to the lab's single-bit half/full add/sub cell. It accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a single add/sub cell and a carry/borrow flip-flop. It reports the result, the final carry/borrow and a signed overflow flag with a done pulse. It sits between the lab's operand registers / switch inputs and the result display logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge active
resetN  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only while busy=0
modeAddSubtract  input  1  0 = add, 1 = subtract (a - b)
modeHalfFull  input  1  0 = half (carry/borrow-in forced 0), 1 = full (use carryborrowIn)
a  input  WIDTH  operand A (minuend when subtracting)
b  input  WIDTH  operand B (subtrahend when subtracting)
carryborrowIn  input  1  initial carry (add) or borrow (subtract); used only when modeHalfFull=1
busy  output  1  high from the edge after start is accepted until the return to IDLE
done  output  1  one-cycle pulse: result outputs valid
sumdiff  output  WIDTH  result; held stable from done until the next accepted start
carryborrowOut  output  1  final carry-out (add) or borrow-out (subtract)
overflow  output  1  signed two's-complement overflow of the result

Behaviour:
- Reset: when resetN=0, all state clears asynchronously. State=IDLE; busy=0, done=0, sumdiff=0, carryborrowOut=0, overflow=0; internal shift registers, bit counter and carry flip-flop cleared.
- Reset asserted mid-operation abandons the operation. No done pulse is issued.
- States and transitions:
  - IDLE -> RUN on a clk edge with start=1.
  - RUN -> DONE after WIDTH bit-cycles.
  - DONE -> IDLE after exactly one cycle.
- Accept edge (edge 0):
  - Capture a, b and both modes into shift registers.
  - Load the carry flip-flop with carryborrowIn & modeHalfFull.
  - Clear the bit counter; set busy=1.
- RUN edges 1..WIDTH: edge k processes bit k-1.
  - Result bit: a_i ^ b_i ^ c.
  - Add carry: a_i&b_i | c&(a_i^b_i).
  - Subtract borrow: ~a_i&b_i | c&~(a_i^b_i).
  - The result bit shifts into the result register from the MSB side.
- Edge WIDTH: last bit processed. Update sumdiff, carryborrowOut and overflow, go to DONE, set done=1.
- Edge WIDTH+1: done=0, busy=0, state=IDLE.
- Latency: start-to-done is WIDTH edges. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. It is not queued.
- a, b, modes and carryborrowIn may change freely after the accept edge without affecting the result.
- Arithmetic:
  - Add: {carryborrowOut, sumdiff} = a + b + cin.
  - Subtract: sumdiff = (a - b - bin) mod 2^WIDTH; carryborrowOut = 1 iff a < b + bin (unsigned).
- Overflow, with MSB = WIDTH-1:
  - Add: a[MSB]==b[MSB] && sumdiff[MSB]!=a[MSB].
  - Subtract: a[MSB]!=b[MSB] && sumdiff[MSB]!=a[MSB].
- WIDTH=1: single RUN cycle; overflow rules apply to bit 0.
- Outputs other than busy/done change only on the done edge.

Decomposition:
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - mode constants MODE_ADD=0, MODE_SUB=1, MODE_HALF=0, MODE_FULL=1;
  - a function returning the counter width, $clog2(WIDTH+1).
- Sub-module addsub_bit_cell: combinational 1-bit full adder/subtractor.
  - Inputs: a, b, c, modeAddSubtract.
  - Outputs: result bit, carry/borrow out.
  - Instantiated once; it is reused by the lab's combinational exercises.

Test Plan:
- Reset mid-run: start at WIDTH=8, assert resetN=0 on the 3rd RUN cycle -> all outputs 0 immediately, no done pulse; a new start after release completes normally.
- Full add: a=8'hF0, b=8'h20, cin=1, add/full -> done exactly 8 edges after the accept edge; sumdiff=8'h11, carryborrowOut=1, overflow=0.
- Half-mode ignore: a=8'h7F, b=8'h01, cin=1, add/half -> sumdiff=8'h80, carryborrowOut=0, overflow=1.
- Subtract with borrow: a=8'h05, b=8'h07, bin=1, sub/full -> sumdiff=8'hFD, carryborrowOut=1, overflow=0. Then a=8'h80, b=8'h01, sub/half -> sumdiff=8'h7F, borrow=0, overflow=1.
- Ignored start and operand stability: pulse start and change a/b every cycle during RUN/DONE -> exactly one done; result matches the operands captured at the accept edge; sumdiff is held after done until the next accepted start.
- WIDTH=1 and WIDTH=32 builds, exhaustive (WIDTH=1) or 1000 random vectors (WIDTH=32), all mode combinations -> outputs match the arithmetic reference model; done latency equals WIDTH.
